// File: rtl/uart_cmd_pkg.sv
// Shared robot command-link definitions: drive command encoding, ASCII command
// table and receiver state encoding. Used by both the transmit and receive ends.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_SPIN  = 3'd5
  } cmd_t;

  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_T = 8'h54;

  typedef struct packed {
    logic hit;
    cmd_t cmd;
  } cmd_lookup_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic cmd_lookup_t ascii_to_cmd(input logic [7:0] ch);
    cmd_lookup_t r;
    r.hit = 1'b1;
    r.cmd = CMD_STOP;
    case (ch)
      ASCII_S: r.cmd = CMD_STOP;
      ASCII_F: r.cmd = CMD_FWD;
      ASCII_B: r.cmd = CMD_BACK;
      ASCII_L: r.cmd = CMD_LEFT;
      ASCII_R: r.cmd = CMD_RIGHT;
      ASCII_T: r.cmd = CMD_SPIN;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial pin; resets to the
// idle-high level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with command decode for the base-station command link.
// Outputs are registered one cycle after the mid-stop-bit sample.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      uart_in,
  output logic [7:0] data_rx,
  output logic      valid,
  output logic      framing_error,
  output logic [2:0] command,
  output logic      cmd_valid,
  output logic      cmd_unknown,
  output rx_state_t dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic        rx_s;
  rx_state_t   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_rx_q, data_rx_d;
  cmd_t        command_q, command_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        cmdv_q, cmdv_d;
  logic        cmdu_q, cmdu_d;
  cmd_lookup_t lookup;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (uart_in),
    .q_o  (rx_s)
  );

  assign lookup = ascii_to_cmd(shift_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_rx_q <= '0;
      command_q <= CMD_STOP;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      cmdv_q    <= 1'b0;
      cmdu_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_rx_q <= data_rx_d;
      command_q <= command_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      cmdv_q    <= cmdv_d;
      cmdu_q    <= cmdu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_rx_d = data_rx_q;
    command_d = command_q;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
    cmdv_d    = 1'b0;
    cmdu_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // A start bit that is high again at its centre was only a glitch.
        if (clk_cnt_q == HALF_TC) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_TC) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught.
        if (clk_cnt_q == FULL_TC) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d   = IDLE;
            valid_d   = 1'b1;
            data_rx_d = shift_q;
            if (lookup.hit) begin
              cmdv_d    = 1'b1;
              command_d = lookup.cmd;
            end else begin
              cmdu_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_rx       = data_rx_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign command       = command_q;
  assign cmd_valid     = cmdv_q;
  assign cmd_unknown   = cmdu_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit: a table of single
// frames plus hand-written back-to-back, framing, glitch and reset sequences.
module tb_uart_cmd_rx;
  import uart_cmd_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_in;
  logic [7:0] data_rx;
  logic       valid;
  logic       framing_error;
  logic [2:0] command;
  logic       cmd_valid;
  logic       cmd_unknown;
  rx_state_t  dbg_state;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_in      (uart_in),
    .data_rx      (data_rx),
    .valid        (valid),
    .framing_error(framing_error),
    .command      (command),
    .cmd_valid    (cmd_valid),
    .cmd_unknown  (cmd_unknown),
    .dbg_state    (dbg_state)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         e_valid;
    int         e_fe;
    int         e_cmdv;
    int         e_cmdu;
    logic [7:0] e_data;
    logic [2:0] e_cmd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid, n_fe, n_cmdv, n_cmdu, n_stray;
  int valid_cyc[$];
  logic [2:0] cmd_log[$];

  // Advance one clock and tally the output pulses seen at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (valid) begin
      n_valid++;
      valid_cyc.push_back(cyc);
    end
    if (framing_error) n_fe++;
    if (cmd_valid) begin
      n_cmdv++;
      cmd_log.push_back(command);
    end
    if (cmd_unknown) n_cmdu++;
    if ((cmd_valid || cmd_unknown) && !valid) n_stray++;
  endtask

  task automatic clear_mon();
    n_valid = 0; n_fe = 0; n_cmdv = 0; n_cmdu = 0; n_stray = 0;
    valid_cyc.delete();
    cmd_log.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic b);
    uart_in = b;
    repeat (CPB) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  vec_t vecs[8];
  int   sc, sc2, lat, gap;
  logic [2:0] c0, c1;
  logic [7:0] tbyte;

  initial begin
    vecs[0] = '{8'h46, 1'b1, 1, 0, 1, 0, 8'h46, 3'd1};  // 'F'
    vecs[1] = '{8'h41, 1'b1, 1, 0, 0, 1, 8'h41, 3'd1};  // 'A' unknown, command holds
    vecs[2] = '{8'h53, 1'b1, 1, 0, 1, 0, 8'h53, 3'd0};  // 'S'
    vecs[3] = '{8'h54, 1'b1, 1, 0, 1, 0, 8'h54, 3'd5};  // 'T'
    vecs[4] = '{8'h00, 1'b1, 1, 0, 0, 1, 8'h00, 3'd5};
    vecs[5] = '{8'hFF, 1'b1, 1, 0, 0, 1, 8'hFF, 3'd5};
    vecs[6] = '{8'h4C, 1'b1, 1, 0, 1, 0, 8'h4C, 3'd3};  // 'L'
    vecs[7] = '{8'h53, 1'b0, 0, 1, 0, 0, 8'h4C, 3'd3};  // bad stop bit

    reset   = 1'b1;
    uart_in = 1'b1;
    clear_mon();
    repeat (4) step();
    check("reset_data_rx", data_rx, 0);
    check("reset_command", command, 0);
    check("reset_valid", valid, 0);
    check("reset_fe", framing_error, 0);
    check("reset_cmd_pulses", {cmd_valid, cmd_unknown}, 0);
    check("reset_state", int'(dbg_state), int'(IDLE));
    reset = 1'b0;
    idle(20);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      send_frame(vecs[i].d, vecs[i].stop, sc);
      idle(24);
      check($sformatf("v%0d_valid_cnt", i), n_valid, vecs[i].e_valid);
      check($sformatf("v%0d_fe_cnt", i), n_fe, vecs[i].e_fe);
      check($sformatf("v%0d_cmdv_cnt", i), n_cmdv, vecs[i].e_cmdv);
      check($sformatf("v%0d_cmdu_cnt", i), n_cmdu, vecs[i].e_cmdu);
      check($sformatf("v%0d_stray", i), n_stray, 0);
      check($sformatf("v%0d_data_rx", i), data_rx, vecs[i].e_data);
      check($sformatf("v%0d_command", i), command, vecs[i].e_cmd);
      if (i == 0) begin
        lat = (valid_cyc.size() > 0) ? valid_cyc[0] - sc : -1;
        n_checks++;
        if (lat < 154 || lat > 156) begin
          n_fail++;
          $display("FAIL latency_F: got %0d cycles, expected 155 +/-1", lat);
        end
      end
    end

    // Back-to-back 'R' then 'L' with no idle gap.
    clear_mon();
    send_frame(ASCII_R, 1'b1, sc);
    send_frame(ASCII_L, 1'b1, sc2);
    idle(24);
    check("b2b_valid_cnt", n_valid, 2);
    check("b2b_cmdv_cnt", n_cmdv, 2);
    gap = (valid_cyc.size() == 2) ? valid_cyc[1] - valid_cyc[0] : -1;
    check("b2b_gap", gap, 160);
    c0 = (cmd_log.size() > 0) ? cmd_log[0] : 3'd7;
    c1 = (cmd_log.size() > 1) ? cmd_log[1] : 3'd7;
    check("b2b_cmd0", c0, 4);
    check("b2b_cmd1", c1, 3);
    check("b2b_data_rx", data_rx, 8'h4C);

    // Stop bit low, line held low, then a good 'B'.
    clear_mon();
    send_frame(8'h53, 1'b0, sc);
    uart_in = 1'b0;
    repeat (40) step();
    check("fe_hold_state", int'(dbg_state), int'(WAIT_IDLE));
    idle(16);
    check("fe_pulse_cnt", n_fe, 1);
    check("fe_valid_cnt", n_valid, 0);
    check("fe_data_rx_held", data_rx, 8'h4C);
    check("fe_state_idle", int'(dbg_state), int'(IDLE));
    clear_mon();
    send_frame(ASCII_B, 1'b1, sc);
    idle(24);
    check("after_fe_valid_cnt", n_valid, 1);
    check("after_fe_data_rx", data_rx, 8'h42);
    check("after_fe_command", command, 2);
    check("after_fe_cmdv_cnt", n_cmdv, 1);

    // Short low glitch on an idle line.
    clear_mon();
    uart_in = 1'b0;
    repeat (5) step();
    idle(40);
    check("glitch_valid_cnt", n_valid, 0);
    check("glitch_fe_cnt", n_fe, 0);
    check("glitch_state", int'(dbg_state), int'(IDLE));
    check("glitch_data_rx", data_rx, 8'h42);

    // Reset in the middle of the data bits of 'T'.
    clear_mon();
    tbyte = ASCII_T;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(tbyte[i]);
    uart_in = tbyte[3];
    repeat (CPB / 2) step();
    check("pre_rst_state", int'(dbg_state), int'(DATA));
    reset   = 1'b1;
    uart_in = 1'b1;
    step();
    reset = 1'b0;
    check("rst_state", int'(dbg_state), int'(IDLE));
    check("rst_command", command, 0);
    check("rst_data_rx", data_rx, 0);
    idle(200);
    check("rst_valid_cnt", n_valid, 0);
    check("rst_fe_cnt", n_fe, 0);
    check("rst_cmd_pulses", n_cmdv + n_cmdu, 0);
    check("rst_command_after", command, 0);
    clear_mon();
    send_frame(ASCII_T, 1'b1, sc);
    idle(24);
    check("post_rst_valid_cnt", n_valid, 1);
    check("post_rst_data_rx", data_rx, 8'h54);
    check("post_rst_command", command, 5);
    check("post_rst_cmdv_cnt", n_cmdv, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- 8N1 UART receiver for the base-station end of the robot command link.
- Deserialises bytes sent by the robot-side transmitter and validates framing.
- Decodes each ASCII command byte back into the 3-bit drive command using the shared command table.
- Sits between the GPIO UART pin and the base-side motor/drive controller.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200 baud); must be at least 4.
- SYNC_STAGES, 2, metastability synchroniser depth on uart_in.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- uart_in  input  1  asynchronous serial line; idle high
- data_rx  output  8  last received byte; held until the next valid byte
- valid  output  1  one-cycle pulse: data_rx updated with a good frame
- framing_error  output  1  one-cycle pulse: stop bit sampled low
- command  output  3  decoded drive command; held until the next cmd_valid
- cmd_valid  output  1  one-cycle pulse, coincident with valid, when the byte is in the command table
- cmd_unknown  output  1  one-cycle pulse, coincident with valid, when the byte is not in the table

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, data_rx=0, command=CMD_STOP (0), all pulses 0, counters 0, synchroniser flops=1 (idle).
- Synchroniser: uart_in passes through SYNC_STAGES flops; the FSM sees only the synchronised bit rx_s.
- IDLE: on rx_s==0, go to START and clear bit_cnt and clk_cnt.
- START: at clk_cnt==CLKS_PER_BIT/2-1, resample rx_s.
  - Low: go to DATA and clear clk_cnt.
  - High: treat as a glitch and return to IDLE with no output.
- DATA: each time clk_cnt==CLKS_PER_BIT-1 (mid-bit), shift rx_s into the shift register LSB-first and clear clk_cnt. After 8 bits, go to STOP.
- STOP: at clk_cnt==CLKS_PER_BIT-1, sample the stop bit.
  - High: on the next cycle, load data_rx, pulse valid and run decode, then go to IDLE.
  - Low: pulse framing_error, leave data_rx unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1 (break/line-low condition), then go to IDLE. No start detection happens in this state.
- Decode (combinational on the shift register, registered with valid):
  - Table hit: set command and pulse cmd_valid.
  - Miss: pulse cmd_unknown and hold command at its previous value.
- Latency: valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling start edge at the pin (±1 for sampling phase).
- Back-to-back frames: a start bit immediately after the stop bit must be caught. Because IDLE is re-entered half a bit early, no gap is needed.
- Reset mid-frame: the FSM aborts to IDLE next cycle, no pulse is emitted, and held outputs return to reset values.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is 3 bits plus the terminal compare. No wrap-around is possible because the counters are cleared at every terminal count.
- No backpressure: the consumer must sample on the pulses. The inter-byte gap is 10 bit-times, so overrun is impossible.

Decomposition:
- Package uart_cmd_pkg, shared with the transmit-side command translator so both ends use one table:
  - cmd_t (3-bit enum): CMD_STOP=0, CMD_FWD=1, CMD_BACK=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_SPIN=5.
  - ASCII constants: 'S'=8'h53, 'F'=8'h46, 'B'=8'h42, 'L'=8'h4C, 'R'=8'h52, 'T'=8'h54, in that order.
  - Function ascii_to_cmd returning {hit, cmd_t}.
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
- Sub-module uart_rx_sync: a parameterised SYNC_STAGES synchroniser with reset value 1.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Send 'F' (0x46) with stop=1 → one valid pulse, data_rx=0x46, cmd_valid with command=1. The valid pulse lands 2+8+144+1=155 cycles (±1) after the start edge.
- Send 'R' then 'L' back-to-back with no idle gap → two valid pulses 160 cycles apart; commands 4 then 3, both with cmd_valid.
- Send 0x41 'A' → valid, data_rx=0x41, cmd_unknown=1, cmd_valid=0, command holds its previous value.
- Send 0x53 with the stop bit forced low, then hold the line low 40 cycles, then send 'B' → framing_error pulse, no valid, data_rx unchanged; then 'B' is decoded normally with command=2.
- Apply a 5-cycle low glitch on an idle line → no valid and no framing_error; the FSM returns to IDLE.
- Assert reset for 1 cycle mid-DATA of 'T' → no pulses, command=0, data_rx=0; the next full 'T' yields command=5.
